// File: rtl/mux_dff_pipe.sv
// rtl/mux_dff_pipe.sv - channel select into an elastic valid/ready register pipeline
//
// Purpose: picks one of NUM_IN WIDTH-bit channels and registers it through
// STAGES elastic stages. The last stage drives q/qbar. This is the registered
// input-select stage placed ahead of datapath blocks that can stall.
//
// Ports:
//   clk        in   1             rising-edge clock
//   rst        in   1             asynchronous active-high reset
//   clr        in   1             synchronous flush of valids, data and sel_err
//   d_in       in   NUM_IN*WIDTH  packed channels, channel i at [i*WIDTH +: WIDTH]
//   sel        in   SEL_W         channel select, sampled with the input beat
//   in_valid   in   1             upstream beat present
//   in_ready   out  1             a beat can be accepted this cycle
//   q          out  WIDTH         last-stage data
//   qbar       out  WIDTH         bitwise inverse of q
//   out_valid  out  1             last stage holds a valid beat
//   out_ready  in   1             downstream accepts the beat
//   sel_err    out  1             sticky: an accepted beat had sel >= NUM_IN
module mux_dff_pipe #(
  parameter int              WIDTH   = 8,
  parameter int              NUM_IN  = 4,
  parameter int              SEL_W   = 2,
  parameter int              STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [NUM_IN*WIDTH-1:0] d_in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        q,
  output logic [WIDTH-1:0]        qbar,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  logic [WIDTH-1:0]  r_data [STAGES];
  logic [STAGES-1:0] r_valid;
  logic              r_sel_err;

  logic [WIDTH-1:0]  w_mux;
  logic              w_sel_ok;
  logic [STAGES-1:0] w_ready;
  logic              w_accept;

  // Out-of-range selects produce zero data; w_sel_ok feeds the sticky flag.
  always_comb begin
    w_mux    = '0;
    w_sel_ok = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        w_mux    = d_in[i*WIDTH +: WIDTH];
        w_sel_ok = 1'b1;
      end
    end
  end

  // Pass-through ready chain, walked from the output back to stage 0 so a
  // full pipe with out_ready high still accepts a beat without a bubble.
  always_comb begin
    logic w_rdy;
    w_rdy   = out_ready;
    w_ready = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_rdy      = !r_valid[k] || w_rdy;
      w_ready[k] = w_rdy;
    end
  end

  assign in_ready = w_ready[0] && !clr && !rst;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= '0;
      r_sel_err <= 1'b0;
      for (int k = 0; k < STAGES; k++) r_data[k] <= RST_VAL;
    end else if (clr) begin
      r_valid   <= '0;
      r_sel_err <= 1'b0;
      for (int k = 0; k < STAGES; k++) r_data[k] <= RST_VAL;
    end else begin
      if (w_ready[0]) begin
        r_valid[0] <= w_accept;
        if (w_accept) r_data[0] <= w_mux;
      end
      // Bubbles move valid=0 forward but leave the data register untouched.
      for (int k = 1; k < STAGES; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) r_data[k] <= r_data[k-1];
        end
      end
      if (w_accept && !w_sel_ok) r_sel_err <= 1'b1;
    end
  end

  assign q         = r_data[STAGES-1];
  assign qbar      = ~q;
  assign out_valid = r_valid[STAGES-1];
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_dff_pipe.sv
// tb/tb_mux_dff_pipe.sv - directed self-checking bench for mux_dff_pipe
module tb_mux_dff_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;

  logic [31:0] d_in;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  q;
  logic [7:0]  qbar;
  logic        out_valid;
  logic        out_ready;
  logic        sel_err;

  logic [23:0] d3_in;
  logic [1:0]  sel3;
  logic        in_valid3;
  logic        in_ready3;
  logic [7:0]  q3;
  logic [7:0]  qbar3;
  logic        out_valid3;
  logic        out_ready3;
  logic        sel_err3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_dff_pipe dut (
    .clk(clk), .rst(rst), .clr(clr), .d_in(d_in), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .q(q), .qbar(qbar),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
  );

  mux_dff_pipe #(.WIDTH(8), .NUM_IN(3), .SEL_W(2), .STAGES(2)) dut3 (
    .clk(clk), .rst(rst), .clr(clr), .d_in(d3_in), .sel(sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .q(q3), .qbar(qbar3),
    .out_valid(out_valid3), .out_ready(out_ready3), .sel_err(sel_err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] stream_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    rst = 1'b1; clr = 1'b0;
    d_in = {8'h44, 8'h33, 8'h22, 8'h11}; sel = 2'd0; in_valid = 1'b0; out_ready = 1'b1;
    d3_in = {8'h33, 8'h22, 8'h11}; sel3 = 2'd0; in_valid3 = 1'b0; out_ready3 = 1'b1;

    // reset state
    #2;
    check("rst_q", 32'(q), 32'h00);
    check("rst_qbar", 32'(qbar), 32'hFF);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_sel_err", 32'(sel_err), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // single beat, sel = 2
    sel = 2'd2; in_valid = 1'b1;
    #1 check("t1_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t1_lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_q", 32'(q), 32'h33);
    check("t1_qbar", 32'(qbar), 32'hCC);
    tick();
    check("t1_drained", 32'(out_valid), 32'd0);

    // streaming sel 0..3 at full throughput
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4);
      sel = 2'(i);
      #1;
      if (i < 4) check($sformatf("stream_in_ready_%0d", i), 32'(in_ready), 32'd1);
      tick();
      if (i >= 1 && i <= 4) begin
        check($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'd1);
        check($sformatf("stream_q_%0d", i), 32'(q), 32'(stream_exp[i-1]));
      end
    end
    check("stream_drained", 32'(out_valid), 32'd0);

    // backpressure: two beats buffer, the third is refused
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 2'd1;
    #1 check("bp_ready_a", 32'(in_ready), 32'd1);
    tick();
    sel = 2'd2;
    #1 check("bp_ready_b", 32'(in_ready), 32'd1);
    tick();
    sel = 2'd3;
    #1 check("bp_ready_full", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_q", 32'(q), 32'h22);
    tick();
    check("bp_hold_q2", 32'(q), 32'h22);
    // full pipe with out_ready high accepts in the same cycle
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd3;
    #1 check("bp_passthru_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_out1", 32'(q), 32'h33);
    check("bp_out1_valid", 32'(out_valid), 32'd1);
    tick();
    check("bp_out2", 32'(q), 32'h44);
    check("bp_out2_valid", 32'(out_valid), 32'd1);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // out-of-range select on the 3-channel instance
    check("oor_err_init", 32'(sel_err3), 32'd0);
    sel3 = 2'd3; in_valid3 = 1'b1;
    tick();
    in_valid3 = 1'b0;
    check("oor_err_set", 32'(sel_err3), 32'd1);
    tick();
    check("oor_valid", 32'(out_valid3), 32'd1);
    check("oor_q", 32'(q3), 32'h00);
    sel3 = 2'd1; in_valid3 = 1'b1;
    tick();
    in_valid3 = 1'b0;
    tick();
    check("oor_next_q", 32'(q3), 32'h22);
    check("oor_err_sticky", 32'(sel_err3), 32'd1);

    // flush with clr while a beat is offered
    out_ready = 1'b0; in_valid = 1'b1;
    sel = 2'd0; tick();
    sel = 2'd1; tick();
    check("clr_pre_valid", 32'(out_valid), 32'd1);
    clr = 1'b1; sel = 2'd3;
    #1 check("clr_in_ready", 32'(in_ready), 32'd0);
    tick();
    clr = 1'b0; in_valid = 1'b0;
    check("clr_out_valid", 32'(out_valid), 32'd0);
    check("clr_q", 32'(q), 32'h00);
    check("clr_sel_err3", 32'(sel_err3), 32'd0);
    out_ready = 1'b1;
    tick();
    check("clr_beat_dropped", 32'(out_valid), 32'd0);
    tick();
    check("clr_beat_dropped2", 32'(out_valid), 32'd0);

    // asynchronous reset between edges
    in_valid = 1'b1; sel = 2'd0;
    tick();
    tick();
    check("arst_pre_valid", 32'(out_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_q", 32'(q), 32'h00);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("arst_no_partial", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
